// File: rtl/spi_mstr_16b_pkg.sv
// Shared types and constants for the 16-bit SPI master.
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  localparam int SPI_WORD_W = 16;
  localparam int SPI_DIV_W  = 5;

  // Divider preset on load: leaves SCLK high for a quarter period before the first fall.
  function automatic int spi_porch(int div_w);
    return (1 << div_w) - (1 << (div_w - 2)) - 1;
  endfunction

endpackage

// File: rtl/spi_mstr_16b_if.sv
// Command/response and serial-pin bundle between the inertial FSM, the SPI master and the sensor.
interface spi_mstr_16b_if;
  import spi_pkg::*;

  logic                  wrt;
  logic [SPI_WORD_W-1:0] cmd;
  logic                  done;
  logic [SPI_WORD_W-1:0] rd_data;
  logic                  SS_n;
  logic                  SCLK;
  logic                  MOSI;
  logic                  MISO;

  modport master (input  wrt, cmd, MISO,
                  output SS_n, SCLK, MOSI, done, rd_data);
  modport slave  (output wrt, cmd, MISO,
                  input  SS_n, SCLK, MOSI, done, rd_data);
endinterface

// File: rtl/spi_mstr_16b.sv
// 16-bit full-duplex SPI master, MSB first, SCLK idles high; sample on rise, shift on fall.
module spi_mstr_16b
  import spi_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_mstr_16b_if.master bus
);

  localparam logic [DIV_W-1:0] PORCH    = DIV_W'(spi_porch(DIV_W));
  localparam logic [DIV_W-1:0] RISE_PH  = {1'b0, {(DIV_W-1){1'b1}}};
  localparam logic [DIV_W-1:0] FALL_PH  = '1;
  localparam logic [4:0]       LAST_CNT = 5'(SPI_WORD_W);

  spi_state_t            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [SPI_WORD_W-1:0] shft_q;
  logic [4:0]            smpl_cnt_q;
  logic                  miso_smpl_q, smpl_pend_q, done_q;
  logic                  rise_ev, shift_ev, last_ev;

  // Divider phase is the incremented count, so SCLK edges and the sample/shift
  // strobes land on the same clk edge.
  assign div_d    = div_q + 1'b1;
  assign rise_ev  = (state_q == SHIFT) && (div_d == RISE_PH);
  assign shift_ev = (state_q == SHIFT) && (div_d == FALL_PH) && smpl_pend_q;
  assign last_ev  = shift_ev && (smpl_cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.wrt) state_d = SHIFT;
      SHIFT:   if (last_ev) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.SS_n = 1'b1;
    bus.SCLK = 1'b1;
    if (state_q == SHIFT) begin
      bus.SS_n = 1'b0;
      bus.SCLK = div_d[DIV_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= PORCH;
      shft_q      <= '0;
      smpl_cnt_q  <= '0;
      miso_smpl_q <= 1'b0;
      smpl_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.wrt) begin
        shft_q      <= bus.cmd;
        div_q       <= PORCH;
        smpl_cnt_q  <= '0;
        smpl_pend_q <= 1'b0;
        done_q      <= 1'b0;
      end
    end else begin
      div_q <= div_d;
      if (rise_ev) begin
        miso_smpl_q <= bus.MISO;
        smpl_cnt_q  <= smpl_cnt_q + 5'd1;
        smpl_pend_q <= 1'b1;
      end
      if (shift_ev) begin
        shft_q      <= {shft_q[SPI_WORD_W-2:0], miso_smpl_q};
        smpl_pend_q <= 1'b0;
      end
      if (last_ev) done_q <= 1'b1;
    end
  end

  assign bus.MOSI    = shft_q[SPI_WORD_W-1];
  assign bus.done    = done_q;
  assign bus.rd_data = shft_q;

endmodule

// File: tb/tb_spi_mstr_16b.sv
// Bench for spi_mstr_16b: a slave model on the pins, table vectors, random words and corner sequences.
module tb_spi_mstr_16b;
  import spi_pkg::*;

  localparam int DIV   = 5;
  localparam int PER   = 1 << DIV;
  // Whole transfer: 16 bit periods plus the quarter-period front porch.
  localparam int EXP_LAT = SPI_WORD_W * PER + PER / 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_mstr_16b_if bus();

  spi_mstr_16b #(.DIV_W(DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave: presents reply MSB first, shifts on each SCLK fall after its first capture.
  logic        loopback;
  logic [15:0] slv_reply, slv_sreg, slv_rx;
  int          slv_cnt;
  logic [15:0] rxq[$];

  assign bus.MISO = loopback ? bus.MOSI : slv_sreg[15];

  always @(negedge bus.SS_n) begin
    slv_sreg = slv_reply;
    slv_cnt  = 0;
  end
  always @(posedge bus.SCLK) if (!bus.SS_n) begin
    slv_rx = {slv_rx[14:0], bus.MOSI};
    slv_cnt++;
    if (slv_cnt == 16) rxq.push_back(slv_rx);
  end
  always @(negedge bus.SCLK) if (!bus.SS_n && slv_cnt > 0) slv_sreg = slv_sreg << 1;

  // Pin monitor sampled between clk edges.
  int   rises, falls, mosi_bad;
  logic prev_sclk = 1'b1, prev_mosi = 1'b0;
  always @(negedge clk) begin
    if (!prev_sclk && bus.SCLK) begin
      rises++;
      if (bus.MOSI !== prev_mosi) mosi_bad++;
    end
    if (prev_sclk && !bus.SCLK) falls++;
    prev_sclk = bus.SCLK;
    prev_mosi = bus.MOSI;
  end

  int ss_hi;

  task automatic start(input logic [15:0] c, input logic [15:0] rep, input bit lb, input bit now);
    if (!now) @(negedge clk);
    bus.cmd   = c;
    bus.wrt   = 1'b1;
    slv_reply = rep;
    loopback  = lb;
    rxq.delete();
    @(posedge clk);
    #1;
    bus.wrt  = 1'b0;
    bus.cmd  = 16'($urandom);
    rises    = 0;
    falls    = 0;
    mosi_bad = 0;
    ss_hi    = 0;
  endtask

  task automatic wait_done(input int inj, output int lat);
    lat = -1;
    for (int k = 1; k <= 2000; k++) begin
      if (k == inj) begin
        bus.wrt = 1'b1;
        bus.cmd = 16'hFFFF;
      end
      @(posedge clk);
      #1;
      if (k == inj) bus.wrt = 1'b0;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.SS_n) ss_hi++;
    end
    if (lat < 0) $display("FAIL wait_done: done never rose within 2000 clks");
  endtask

  task automatic check_xfer(input string nm, input int lat, input logic [15:0] exp_rd,
                            input logic [15:0] exp_rx);
    chk({nm, ".latency"}, 32'(lat), 32'(EXP_LAT));
    chk({nm, ".rd_data"}, {16'h0, bus.rd_data}, {16'h0, exp_rd});
    chk({nm, ".ss_low"}, 32'(ss_hi), 32'd0);
    chk({nm, ".rises"}, 32'(rises), 32'd16);
    chk({nm, ".falls"}, 32'(falls), 32'd16);
    chk({nm, ".mosi_stable"}, 32'(mosi_bad), 32'd0);
    chk({nm, ".slave_words"}, 32'(rxq.size()), 32'd1);
    chk({nm, ".slave_rx"}, {16'h0, (rxq.size() > 0) ? rxq[0] : 16'hxxxx}, {16'h0, exp_rx});
  endtask

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] rep;
    bit          lb;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vt[4];

  initial begin
    int          lat, bad;
    logic [15:0] c, r;
    bit          lb;

    vt[0] = '{16'hA5C3, 16'h0000, 1'b1, 16'hA5C3};
    vt[1] = '{16'hA400, 16'h0071, 1'b0, 16'h0071};
    vt[2] = '{16'h0000, 16'hFFFF, 1'b0, 16'hFFFF};
    vt[3] = '{16'hFFFF, 16'h0000, 1'b0, 16'h0000};

    bus.wrt = 1'b0; bus.cmd = '0;
    loopback = 1'b0; slv_reply = '0; slv_sreg = '0; slv_rx = '0; slv_cnt = 0;
    rises = 0; falls = 0; mosi_bad = 0; ss_hi = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #20;
    chk("reset.SS_n", {31'h0, bus.SS_n}, 32'd1);
    chk("reset.SCLK", {31'h0, bus.SCLK}, 32'd1);
    chk("reset.done", {31'h0, bus.done}, 32'd0);
    chk("reset.MOSI", {31'h0, bus.MOSI}, 32'd0);
    chk("reset.rd_data", {16'h0, bus.rd_data}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(posedge clk);
      #1;
      if (bus.SCLK !== 1'b1 || bus.SS_n !== 1'b1 || bus.done !== 1'b0) bad++;
    end
    chk("idle.quiet", 32'(bad), 32'd0);

    foreach (vt[i]) begin
      start(vt[i].cmd, vt[i].rep, vt[i].lb, 1'b0);
      wait_done(0, lat);
      check_xfer($sformatf("vec%0d", i), lat, vt[i].exp_rd, vt[i].cmd);
    end

    for (int i = 0; i < 6; i++) begin
      c  = 16'($urandom);
      r  = 16'($urandom);
      lb = ($urandom_range(0, 3) == 0);
      start(c, r, lb, 1'b0);
      wait_done(0, lat);
      check_xfer($sformatf("rand%0d", i), lat, lb ? c : r, c);
    end

    start(16'h0D02, 16'h6E19, 1'b0, 1'b0);
    wait_done(0, lat);
    check_xfer("b2b.first", lat, 16'h6E19, 16'h0D02);
    start(16'h1053, 16'hC0DE, 1'b0, 1'b1);
    chk("b2b.done_clr", {31'h0, bus.done}, 32'd0);
    chk("b2b.ss_low", {31'h0, bus.SS_n}, 32'd0);
    wait_done(0, lat);
    check_xfer("b2b.second", lat, 16'hC0DE, 16'h1053);

    start(16'h3C96, 16'h5AA5, 1'b0, 1'b0);
    wait_done(100, lat);
    check_xfer("ignore_wrt", lat, 16'h5AA5, 16'h3C96);

    start(16'h7E81, 16'h9137, 1'b0, 1'b0);
    repeat (299) @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.SS_n", {31'h0, bus.SS_n}, 32'd1);
    chk("abort.SCLK", {31'h0, bus.SCLK}, 32'd1);
    chk("abort.done", {31'h0, bus.done}, 32'd0);
    chk("abort.rd_data", {16'h0, bus.rd_data}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    start(16'h1460, 16'h2B4D, 1'b0, 1'b0);
    wait_done(0, lat);
    check_xfer("after_abort", lat, 16'h2B4D, 16'h1460);

    repeat (40) @(posedge clk);
    #1;
    chk("sticky.done", {31'h0, bus.done}, 32'd1);
    chk("hold.rd_data", {16'h0, bus.rd_data}, 32'h2B4D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_mstr_16b.md
Name: spi_mstr_16b

Overview:
- 16-bit SPI master; serial transport between the inertial-interface FSM and the inertial sensor.
- Accepts a 16-bit command with a one-cycle `wrt` strobe and runs one full-duplex transaction, MSB first.
- Drives `SS_n`, `SCLK` and `MOSI`; returns the 16 bits shifted in from `MISO` on `rd_data` and flags completion with `done`.
- Consumer issues the next `wrt` in the cycle it sees `done` high.

Parameters:
- DIV_W, 5: SCLK divider width; SCLK period = 2^DIV_W clk cycles (32 at default).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- wrt  input  1  start strobe; sampled only in IDLE
- cmd  input  16  word to transmit; captured on the `wrt` edge
- MISO  input  1  serial data from slave
- SS_n  output  1  active-low slave select
- SCLK  output  1  serial clock, idles high
- MOSI  output  1  serial data to slave; equals shft[15]
- done  output  1  transaction complete; sticky
- rd_data  output  16  received word; equals shift register contents

Behaviour:
- Reset values: SS_n=1, SCLK=1, done=0, shft=16'h0000, so MOSI=0 and rd_data=0. State=IDLE, div=front-porch preset, smpl_pend=0.
- Reset asserted mid-transaction aborts immediately to these values; no partial `done`.
- Internal registers:
  - `div[DIV_W-1:0]`: free-running only in SHIFT.
  - `shft[15:0]`.
  - `miso_smpl`: 1-bit MISO capture.
  - `smpl_cnt[4:0]`: counts samples taken.
  - `smpl_pend`: a sample has been taken but not yet shifted in.
- SCLK = div[DIV_W-1] in SHIFT; forced 1 in IDLE.
- States: IDLE, SHIFT (enum `spi_state_t`).
- IDLE:
  - SS_n=1.
  - On `wrt`: shft<=cmd, div<=PORCH, smpl_cnt<=0, smpl_pend<=0, done<=0, SS_n<=0, go to SHIFT.
  - PORCH = 2^DIV_W - 2^(DIV_W-2) - 1 (5'b10111 at default), which gives an 8-clk SCLK-high front porch.
- SHIFT:
  - div increments every clk.
  - When div == {0,1...1} (01111), i.e. on the edge where SCLK rises: miso_smpl<=MISO, smpl_cnt++, smpl_pend<=1.
  - When div == all-ones (11111), i.e. the SCLK falling edge, and smpl_pend=1: shft<={shft[14:0],miso_smpl}, smpl_pend<=0.
  - The first falling edge has no pending sample, so it does not shift.
  - When the shift happens with smpl_cnt==16: done<=1, SS_n<=1, go to IDLE. SCLK returns high without producing a 17th fall.
- Timing, with edge 0 = the edge that accepts `wrt`:
  - Sample n (1..16) occurs at edge 24+32(n-1).
  - Shift n occurs at edge 8+32n.
  - done and SS_n rise at edge 520.
  - SS_n is low for exactly 520 clks.
  - Exactly 16 SCLK falls and 16 SCLK rises per transaction.
- `wrt` while in SHIFT: ignored; cmd is not re-sampled.
- `done` remains 1 until the next accepted `wrt`, which clears it on that edge.
- `wrt` in the same cycle `done` is high (back-to-back transfers): legal. The new transaction starts with no idle gap.
- rd_data is valid whenever done=1 and holds until the next transaction starts shifting.
- MOSI changes only on SCLK falling edges (or at load); it is stable across each rising edge.

Decomposition:
- Package `spi_pkg`:
  - typedef `spi_state_t` {IDLE, SHIFT}.
  - Constants SPI_WORD_W=16 and SPI_DIV_W=5.
  - PORCH computed as a function of DIV_W.
- No sub-module needed; divider, shifter and FSM live in one module of about 150 lines.

Test Plan:
- Loopback (MISO tied to MOSI), cmd=16'hA5C3, wrt pulse -> done rises exactly 520 clks later, rd_data=16'hA5C3, SS_n low for the entire 520 clks.
- Slave model returns 16'h0071 for cmd=16'hA400 -> rd_data[7:0]=8'h71. Bench checks MOSI stable at every SCLK rise and exactly 16 SCLK rises and 16 falls.
- Back-to-back: wrt with cmd=16'h0D02, then wrt=1 in the first done=1 cycle with cmd=16'h1053 -> second transaction starts with no idle cycle, done is cleared that edge, and the slave receives both words.
- wrt pulsed at edge 100 of an active transfer with cmd=16'hFFFF -> ignored. Original word is completed unchanged and done rises at edge 520.
- rst_n asserted at edge 300 -> SS_n=1, SCLK=1, done=0, rd_data=0 immediately. A subsequent wrt with cmd=16'h1460 completes normally in 520 clks.
- Idle check: no wrt for 1000 clks after reset -> SCLK=1, SS_n=1, done=0 throughout.
